// File: rtl/regfile_wport_sched_if.sv
// Port bundle for the register-file write-port scheduler: writeback, long-latency
// result, pending-write lookup and registered write-port outputs.
interface regfile_wport_sched_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
);
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_stall;
    logic          lu_valid;
    logic          lu_ready;
    logic [AW-1:0] lu_addr;
    logic [DW-1:0] lu_data;
    logic [AW-1:0] chk_a1;
    logic [AW-1:0] chk_a2;
    logic          pend1;
    logic          pend2;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic          init_busy;

    modport master (
        output wb_we, wb_addr, wb_data, lu_valid, lu_addr, lu_data, chk_a1, chk_a2,
        input  wb_stall, lu_ready, pend1, pend2, rf_we, rf_addr, rf_wdata, init_busy
    );

    modport slave (
        input  wb_we, wb_addr, wb_data, lu_valid, lu_addr, lu_data, chk_a1, chk_a2,
        output wb_stall, lu_ready, pend1, pend2, rf_we, rf_addr, rf_wdata, init_busy
    );
endinterface

// File: rtl/regfile_wport_sched.sv
// Register-file write-port scheduler: zero-fills all registers after reset, then
// arbitrates the single write port between writeback and a buffered long-latency unit.
module regfile_wport_sched #(
    parameter int unsigned NREGS      = 32,
    parameter int unsigned AW         = 5,
    parameter int unsigned DW         = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wport_sched_if.slave bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIM + 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] init_cnt, init_cnt_nxt;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic          rf_we, rf_we_nxt;
    logic [AW-1:0] rf_addr, rf_addr_nxt;
    logic [DW-1:0] rf_wdata, rf_wdata_nxt;
    logic          rf_src_lu, rf_src_nxt;
    logic          wb_stall_c, lu_ready_c;
    logic          pop, push, empty, full;
    logic          hit1, hit2;

    logic [AW-1:0] fifo_addr [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    // Register-0 results complete the handshake but are never stored
    assign push  = bus.lu_valid && lu_ready_c && (bus.lu_addr != '0);

    // Next-state and write-port decision
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        rf_we_nxt    = 1'b0;
        rf_addr_nxt  = rf_addr;
        rf_wdata_nxt = rf_wdata;
        rf_src_nxt   = 1'b0;
        pop          = 1'b0;
        wb_stall_c   = 1'b1;
        lu_ready_c   = 1'b0;
        case (state)
            S_INIT: begin
                rf_we_nxt    = 1'b1;
                rf_addr_nxt  = init_cnt;
                rf_wdata_nxt = '0;
                init_cnt_nxt = init_cnt + AW'(1);
                if (init_cnt == AW'(NREGS - 1)) state_nxt = S_RUN;
            end
            S_RUN: begin
                lu_ready_c = !full;
                wb_stall_c = 1'b0;
                if (!empty && (starve_cnt == SW'(STARVE_LIM))) begin
                    pop        = 1'b1;
                    wb_stall_c = 1'b1;
                end else if (bus.wb_we) begin
                    rf_we_nxt    = (bus.wb_addr != '0);
                    rf_addr_nxt  = bus.wb_addr;
                    rf_wdata_nxt = bus.wb_data;
                end else if (!empty) begin
                    pop = 1'b1;
                end
                if (pop) begin
                    rf_we_nxt    = 1'b1;
                    rf_addr_nxt  = fifo_addr[rd_ptr];
                    rf_wdata_nxt = fifo_data[rd_ptr];
                    rf_src_nxt   = 1'b1;
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // Starvation counter: counts RUN cycles a queued result waits without a slot
    always_comb begin
        starve_nxt = '0;
        if ((state == S_RUN) && !empty && !pop)
            starve_nxt = (starve_cnt == SW'(STARVE_LIM)) ? starve_cnt : starve_cnt + SW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_INIT;
            init_cnt   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            rf_we      <= 1'b0;
            rf_addr    <= '0;
            rf_wdata   <= '0;
            rf_src_lu  <= 1'b0;
        end else begin
            state      <= state_nxt;
            init_cnt   <= init_cnt_nxt;
            starve_cnt <= starve_nxt;
            rf_we      <= rf_we_nxt;
            rf_addr    <= rf_addr_nxt;
            rf_wdata   <= rf_wdata_nxt;
            rf_src_lu  <= rf_src_nxt;
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.lu_addr;
            fifo_data[wr_ptr] <= bus.lu_data;
        end
    end

    // Pending lookup over valid FIFO entries plus a FIFO-sourced slot on rf_*
    always_comb begin
        hit1 = rf_we && rf_src_lu && (rf_addr == bus.chk_a1);
        hit2 = rf_we && rf_src_lu && (rf_addr == bus.chk_a2);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                if (fifo_addr[rd_ptr + PW'(i)] == bus.chk_a1) hit1 = 1'b1;
                if (fifo_addr[rd_ptr + PW'(i)] == bus.chk_a2) hit2 = 1'b1;
            end
        end
    end

    assign bus.pend1     = (state == S_RUN) && (bus.chk_a1 != '0) && hit1;
    assign bus.pend2     = (state == S_RUN) && (bus.chk_a2 != '0) && hit2;
    assign bus.wb_stall  = wb_stall_c;
    assign bus.lu_ready  = lu_ready_c;
    assign bus.init_busy = (state == S_INIT);
    assign bus.rf_we     = rf_we;
    assign bus.rf_addr   = rf_addr;
    assign bus.rf_wdata  = rf_wdata;
endmodule

// File: doc/regfile_wport_sched.md
Name: regfile_wport_sched

Overview:
- Schedules the register file's single write port (WE3/A3/WD3) after reset.
- At reset exit, sequences a zero-fill of every register. It then arbitrates the port between the pipeline writeback stage and a long-latency unit (multiply/divide/load miss); the long-latency unit is buffered in a small FIFO.
- Provides pending-write lookups so hazard logic can stall readers of registers with queued long-latency results.

Parameters:
- NREGS, 32, number of architectural registers; must be a power of two.
- AW, 5, register address width, equal to log2(NREGS).
- DW, 32, data width.
- DEPTH, 2, long-latency FIFO depth; must be a power of two, 2 or greater.
- STARVE_LIM, 4, number of consecutive cycles a non-empty FIFO may be denied before it is forced a slot.

Ports:
- clk, in, 1, system clock; all state updates on the rising edge.
- rst, in, 1, asynchronous, active-high reset.
- wb_we, in, 1, pipeline writeback request.
- wb_addr, in, AW, writeback destination register.
- wb_data, in, DW, writeback data.
- wb_stall, out, 1, writeback not accepted this cycle; the pipeline holds its request and freezes.
- lu_valid, in, 1, long-latency result valid.
- lu_ready, out, 1, FIFO can accept a result.
- lu_addr, in, AW, long-latency result destination register.
- lu_data, in, DW, long-latency result data.
- chk_a1, in, AW, first register address to check for a pending write.
- chk_a2, in, AW, second register address to check for a pending write.
- pend1, out, 1, a long-latency write to chk_a1 is pending.
- pend2, out, 1, a long-latency write to chk_a2 is pending.
- rf_we, out, 1, registered write enable to the register file.
- rf_addr, out, AW, registered write address.
- rf_wdata, out, DW, registered write data.
- init_busy, out, 1, zero-fill sequence in progress.

Behaviour:
- Clock/reset: one clock, clk; reset rst is asynchronous, active-high.
- While rst is high: state=INIT, init_cnt=0, FIFO empty, starve_cnt=0, rf_we=0, rf_addr=0, rf_wdata=0.
- Combinational outputs during reset: init_busy=1, wb_stall=1, lu_ready=0.
- rf_* outputs are registered. A decision made in cycle N appears on rf_* in cycle N+1 and is written at the end of cycle N+1.
- INIT state, one write per cycle:
  - Each cycle drive rf_we=1, rf_addr=init_cnt, rf_wdata=0, then increment init_cnt.
  - After the decision for NREGS-1, move to RUN.
  - init_busy=1 throughout INIT; it falls the cycle after the last write is issued.
  - During INIT, wb_stall=1 and lu_ready=0.
- RUN state, per-cycle priority:
  - Forced slot: if the FIFO is non-empty and starve_cnt==STARVE_LIM, pop the FIFO head to rf_* and assert wb_stall=1.
  - Otherwise, if wb_we=1, wb owns the slot: rf_we=(wb_addr!=0), rf_addr=wb_addr, rf_wdata=wb_data, wb_stall=0.
  - Otherwise, if the FIFO is non-empty, pop its head to rf_*.
  - Otherwise rf_we=0; rf_addr and rf_wdata hold their previous values.
- wb_stall is combinational. It is 0 in RUN except in the forced-slot cycle.
- Writes to register 0 are never issued with rf_we=1:
  - wb to register 0 is accepted and dropped.
  - lu to register 0 is accepted (handshake completes) but not enqueued.
- lu_ready = (state==RUN) && !full. Enqueue happens on lu_valid && lu_ready.
- Simultaneous pop and push on a full FIFO: lu_ready is still 0 (no bypass).
- FIFO is in-order with wrapping read/write pointers and a count of 0..DEPTH.
- starve_cnt:
  - Increments, saturating at STARVE_LIM, on each RUN cycle the FIFO is non-empty and not popped.
  - Clears on any pop and whenever the FIFO is empty.
- pend1 (likewise pend2) is asserted when chk_a1!=0 and either condition holds:
  - a valid FIFO entry has addr==chk_a1;
  - the current rf_* slot has rf_we=1 and addr==chk_a1, and that slot came from the FIFO (a source flag is registered alongside rf_*).
- pend1/pend2 are purely combinational; forced to 0 in INIT.
- Ordering: the pipeline's hazard logic stalls issue while a pend signal is high, so wb never overtakes a queued lu write to the same register. The block itself does no reordering checks.
- Reset asserted mid-INIT or mid-RUN: immediately returns to the reset values; the FIFO contents are discarded. The zero-fill restarts from register 0 after release.

Test Plan:
- Reset release → 32 consecutive cycles of rf_we=1, rf_addr 0..31, rf_wdata=0. init_busy falls after register 31 is issued. lu_ready=0 and wb_stall=1 throughout.
- RUN, wb_we=1, wb_addr=5, wb_data=0xDEADBEEF → next cycle rf_we=1, rf_addr=5, rf_wdata=0xDEADBEEF, and wb_stall=0.
- lu push (addr=7, data=0x12) while wb is idle:
  - while queued, chk_a1=7 gives pend1=1;
  - next cycle rf_* = 7/0x12, and pend1 stays 1 while the slot is on rf_*;
  - one cycle later pend1=0.
- Two lu pushes (addr 3 and 4) while wb_we is held continuously:
  - FIFO fills and lu_ready=0;
  - after 4 denied cycles, wb_stall=1 for one cycle and register 3 is issued;
  - starve_cnt clears, then after 4 more denied cycles register 4 is issued.
- wb_addr=0 and lu_addr=0 → rf_we stays 0, the lu handshake completes, the FIFO count is unchanged, and pend checks on register 0 read 0.
- rst pulsed at init_cnt=10 and again with 2 FIFO entries in RUN → all outputs return to reset values, the FIFO is empty, and the zero-fill restarts at register 0.
